// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive path and the matching sender.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS  = 8;
   localparam int unsigned UART_FRAME_BITS = 11;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_rx_state_t;

   // Even parity over one data byte.
   function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: rx synchroniser, frame FSM and bit-centre timing.
// Emits one strobe per completed frame with the stop/parity status attached;
// the strobe appears in the cycle after the stop-bit centre sample.
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] byte_data,
   output logic       byte_strobe,
   output logic       stop_bad,
   output logic       parity_bad
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

   logic           meta_q, sync_q, prev_q;
   logic [1:0]     fill_q;
   logic           fall;
   uart_rx_state_t state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2:0]     bit_q, bit_d;
   logic [7:0]     shift_q, shift_d;
   logic           par_q, par_d;
   logic           strobe_q, strobe_d;
   logic           stop_bad_q, stop_bad_d;
   logic           par_bad_q, par_bad_d;

   // Two-flop synchroniser plus edge history. fill_q keeps prev_q at 0 until the
   // synchroniser holds a real sample, so after reset rx must be seen high
   // before a falling edge is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         fill_q <= '0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= rx;
         sync_q <= meta_q;
         fill_q <= {fill_q[0], 1'b1};
         prev_q <= sync_q & fill_q[1];
      end
   end

   assign fall = prev_q & ~sync_q;

   // Frame FSM and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         strobe_q   <= 1'b0;
         stop_bad_q <= 1'b0;
         par_bad_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         strobe_q   <= strobe_d;
         stop_bad_q <= stop_bad_d;
         par_bad_q  <= par_bad_d;
      end
   end

   // Next-state logic: half-bit wait validates the start bit, then one
   // sample per bit period at the bit centre.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CW'(1);
      bit_d      = bit_q;
      shift_d    = shift_q;
      par_d      = par_q;
      strobe_d   = 1'b0;
      stop_bad_d = 1'b0;
      par_bad_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (fall) state_d = START;
         end
         START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d = '0;
               if (sync_q) begin
                  state_d = IDLE;
               end else begin
                  state_d = DATA;
                  bit_d   = '0;
               end
            end
         end
         DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               shift_d = {sync_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = PARITY;
            end
         end
         PARITY: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               par_d   = sync_q;
               state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d      = '0;
               state_d    = IDLE;
               strobe_d   = 1'b1;
               stop_bad_d = ~sync_q;
               par_bad_d  = (par_q != uart_parity(shift_q));
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign byte_data   = shift_q;
   assign byte_strobe = strobe_q;
   assign stop_bad    = stop_bad_q;
   assign parity_bad  = par_bad_q;

endmodule

// File: rtl/uart_recv.sv
// UART receiver top: assembles received bytes into a PACKET_SIZE-bit packet
// with a valid/clear handshake and one-cycle error pulses.
// Optional feature macro: UART_RECV_PARITY_EN (enables parity checking).
module uart_recv
   import uart_pkg::*;
#(
   parameter int unsigned PACKET_SIZE  = 32,
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 rx,
   input  logic                                 packet_clear,
   output logic [PACKET_SIZE-1:0]               packet,
   output logic                                 packet_valid,
   output logic [$clog2(PACKET_SIZE/8+1)-1:0]   byte_count,
   output logic                                 frame_err,
   output logic                                 parity_err,
   output logic                                 overrun
);

   localparam int unsigned NBYTES = PACKET_SIZE / UART_DATA_BITS;
   localparam int unsigned CNT_W  = $clog2(PACKET_SIZE/8+1);
   localparam logic [CNT_W-1:0] NB_CNT = CNT_W'(NBYTES);

   logic [7:0]             byte_data;
   logic                   byte_strobe, byte_stop_bad, byte_parity_bad;
   logic                   par_reject;
   logic [PACKET_SIZE-1:0] packet_q, packet_d;
   logic                   valid_q, valid_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   ferr_q, ferr_d;
   logic                   perr_q, perr_d;
   logic                   ovr_q, ovr_d;

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx          (rx),
      .byte_data   (byte_data),
      .byte_strobe (byte_strobe),
      .stop_bad    (byte_stop_bad),
      .parity_bad  (byte_parity_bad)
   );

`ifdef UART_RECV_PARITY_EN
   assign par_reject = byte_parity_bad;
`else
   logic unused_parity_bad;
   assign unused_parity_bad = byte_parity_bad;
   assign par_reject        = 1'b0;
`endif

   // Packet assembly. Clear is applied before the incoming byte is
   // considered, so a byte arriving with packet_clear lands as byte 0.
   always_comb begin
      packet_d = packet_q;
      valid_d  = valid_q;
      count_d  = count_q;
      ferr_d   = 1'b0;
      perr_d   = 1'b0;
      ovr_d    = 1'b0;
      if (packet_clear) begin
         valid_d = 1'b0;
         count_d = '0;
      end
      if (byte_strobe) begin
         if (byte_stop_bad) begin
            ferr_d = 1'b1;
         end else if (par_reject) begin
            perr_d = 1'b1;
         end else if (valid_d) begin
            ovr_d = 1'b1;
         end else begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
               if (count_d == CNT_W'(i)) packet_d[i*8 +: 8] = byte_data;
            end
            count_d = count_d + CNT_W'(1);
            if (count_d == NB_CNT) valid_d = 1'b1;
         end
      end
   end

   // Packet, handshake and error-pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         packet_q <= '0;
         valid_q  <= 1'b0;
         count_q  <= '0;
         ferr_q   <= 1'b0;
         perr_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         packet_q <= packet_d;
         valid_q  <= valid_d;
         count_q  <= count_d;
         ferr_q   <= ferr_d;
         perr_q   <= perr_d;
         ovr_q    <= ovr_d;
      end
   end

   assign packet       = packet_q;
   assign packet_valid = valid_q;
   assign byte_count   = count_q;
   assign frame_err    = ferr_q;
   assign parity_err   = perr_q;
   assign overrun      = ovr_q;

endmodule

// File: tb/tb_uart_recv.sv
// Scoreboard bench for uart_recv (PACKET_SIZE=32, CLKS_PER_BIT=16).
// Stimulus pushes the expected event for each frame; a negedge monitor pops
// and compares whenever the DUT stores a byte or pulses an error flag.
module tb_uart_recv;
   import uart_pkg::*;

   localparam int CPB = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx;
   logic        packet_clear;
   logic [31:0] packet;
   logic        packet_valid;
   logic [2:0]  byte_count;
   logic        frame_err, parity_err, overrun;

   // flags: {store, frame_err, parity_err, overrun}
   typedef struct packed {
      logic [3:0]  flags;
      logic [2:0]  cnt;
      logic        valid;
      logic [31:0] pkt;
   } ev_t;

   localparam logic [3:0] F_STORE = 4'b1000;
   localparam logic [3:0] F_FERR  = 4'b0100;
   localparam logic [3:0] F_PERR  = 4'b0010;
   localparam logic [3:0] F_OVR   = 4'b0001;

   ev_t        exp_q[$];
   int         compared   = 0;
   int         mismatched = 0;
   logic [2:0] prev_cnt   = '0;
   int         rise_n;

   uart_recv #(
      .PACKET_SIZE  (32),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx           (rx),
      .packet_clear (packet_clear),
      .packet       (packet),
      .packet_valid (packet_valid),
      .byte_count   (byte_count),
      .frame_err    (frame_err),
      .parity_err   (parity_err),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void expect_ev(input logic [3:0] f, input logic [2:0] c,
                                     input logic v, input logic [31:0] p);
      ev_t e;
      e.flags = f;
      e.cnt   = c;
      e.valid = v;
      e.pkt   = p;
      exp_q.push_back(e);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: any store or error pulse is an event to be matched in order.
   always @(negedge clk) begin
      ev_t act, exp;
      if (rst_n) begin
         act.flags = {(byte_count != prev_cnt) && (byte_count != 3'd0),
                      frame_err, parity_err, overrun};
         act.cnt   = byte_count;
         act.valid = packet_valid;
         act.pkt   = packet;
         if (act.flags != 4'b0000) begin
            compared++;
            if (exp_q.size() == 0) begin
               mismatched++;
               $display("FAIL unexpected_event: flags=%b cnt=%0d valid=%b pkt=%h",
                        act.flags, act.cnt, act.valid, act.pkt);
            end else begin
               exp = exp_q.pop_front();
               if (act !== exp) begin
                  mismatched++;
                  $display("FAIL event: actual flags=%b cnt=%0d valid=%b pkt=%h required flags=%b cnt=%0d valid=%b pkt=%h",
                           act.flags, act.cnt, act.valid, act.pkt,
                           exp.flags, exp.cnt, exp.valid, exp.pkt);
               end
            end
         end
      end
      prev_cnt <= byte_count;
   end

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Sends one frame; n counts posedges from the first start-bit edge (n=0).
   // rise_o reports the n at which packet_valid first went high (-1 if never).
   task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                             input int abort_at, input int clr_at, output int rise_o);
      logic [10:0] bits;
      logic        was;
      int          n;
      bits   = {s, p, d, 1'b0};
      was    = packet_valid;
      rise_o = -1;
      for (int b = 0; b < 11; b++) begin
         rx = bits[b];
         for (int c = 0; c < CPB; c++) begin
            @(posedge clk);
            n = b * CPB + c;
            #1;
            if (rise_o < 0 && !was && packet_valid) rise_o = n;
            if (clr_at >= 0 && n == clr_at) packet_clear = 1'b1;
            if (clr_at >= 0 && n == clr_at + 1) packet_clear = 1'b0;
            if (n == abort_at) return;
         end
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      rx           = 1'b1;
      packet_clear = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_packet", packet, 32'h0);
      check("reset_valid", 32'(packet_valid), 32'h0);
      check("reset_count", 32'(byte_count), 32'h0);
      check("reset_ferr", 32'(frame_err), 32'h0);
      check("reset_perr", 32'(parity_err), 32'h0);
      check("reset_ovr", 32'(overrun), 32'h0);
      rst_n = 1'b1;
      idle(10);

      // Short low glitch: false start, nothing stored.
      rx = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      idle(30);
      check("glitch_count", 32'(byte_count), 32'h0);
      check("glitch_state", 32'(dut.u_rx.state_q), 32'(IDLE));

      // Bad stop bit.
      expect_ev(F_FERR, 3'd0, 1'b0, 32'h0);
      send_frame(8'h3C, 1'b0, 1'b0, -1, -1, rise_n);
      idle(20);

      // Bad parity (correct parity of 0x01 is 1).
`ifdef UART_RECV_PARITY_EN
      expect_ev(F_PERR, 3'd0, 1'b0, 32'h0);
`else
      expect_ev(F_STORE, 3'd1, 1'b0, 32'h0000_0001);
`endif
      send_frame(8'h01, 1'b0, 1'b1, -1, -1, rise_n);
      idle(10);
      packet_clear = 1'b1;
      @(posedge clk);
      #1;
      packet_clear = 1'b0;
      idle(10);
      check("clear_count", 32'(byte_count), 32'h0);

      // Four good bytes; stale byte 0 is overwritten.
      expect_ev(F_STORE, 3'd1, 1'b0, 32'h0000_0055);
      send_frame(8'h55, 1'b0, 1'b1, -1, -1, rise_n);
      idle(5);
      expect_ev(F_STORE, 3'd2, 1'b0, 32'h0000_A355);
      send_frame(8'hA3, 1'b0, 1'b1, -1, -1, rise_n);
      idle(5);
      expect_ev(F_STORE, 3'd3, 1'b0, 32'h000F_A355);
      send_frame(8'h0F, 1'b0, 1'b1, -1, -1, rise_n);
      idle(5);
      expect_ev(F_STORE, 3'd4, 1'b1, 32'hF00F_A355);
      send_frame(8'hF0, 1'b0, 1'b1, -1, -1, rise_n);
      check("valid_latency", rise_n, 32'd171);
      idle(5);
      check("full_packet", packet, 32'hF00F_A355);

      // Fifth byte while valid: overrun, packet kept.
      expect_ev(F_OVR, 3'd4, 1'b1, 32'hF00F_A355);
      send_frame(8'h77, 1'b0, 1'b1, -1, -1, rise_n);
      idle(5);

      // Same byte with packet_clear held across the store edge (n=171).
      expect_ev(F_STORE, 3'd1, 1'b0, 32'hF00F_A377);
      send_frame(8'h77, 1'b0, 1'b1, -1, 170, rise_n);
      idle(5);
      check("clear_store_valid", 32'(packet_valid), 32'h0);

      // Reset mid-DATA of the second byte: asynchronous clear.
      send_frame(8'h12, 1'b0, 1'b1, 60, -1, rise_n);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_packet", packet, 32'h0);
      check("async_rst_count", 32'(byte_count), 32'h0);
      check("async_rst_valid", 32'(packet_valid), 32'h0);
      repeat (3) @(posedge clk);
      #1;
      rx    = 1'b1;
      rst_n = 1'b1;
      idle(20);
      expect_ev(F_STORE, 3'd1, 1'b0, 32'h0000_00AA);
      send_frame(8'hAA, 1'b0, 1'b1, -1, -1, rise_n);
      idle(50);

      check("queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
